// File: rtl/serial_word_packer.sv
// Packs a serial bit stream into WIDTH-bit words with valid/ready output; word_valid rises one cycle after
// the last bit (or flush). Backpressure holds the output word and deasserts bit_ready once a word is waiting.
module serial_word_packer #(
  parameter int   WIDTH     = 32,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic PAD_BIT   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           word_out,
  output logic [$clog2(WIDTH+1)-1:0] word_len,
  output logic                       word_valid,
  input  logic                       word_ready
);

  localparam int            CW   = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] sr, sr_nxt, shifted, keep_mask, assembled;
  logic [CW-1:0]    cnt, cnt_nxt, pad_cnt;
  logic             flush_pend, accept, slot_free, full, flush_req, emit;

  assign bit_ready = (cnt != FULL) && !flush_pend;
  assign accept    = bit_valid && bit_ready;
  assign slot_free = !word_valid || word_ready;

  always_comb begin
    sr_nxt = sr;
    if (accept) begin
      if (MSB_FIRST) sr_nxt = {sr[WIDTH-2:0], bit_in};
      else           sr_nxt = {bit_in, sr[WIDTH-1:1]};
    end
  end

  assign cnt_nxt = cnt + {{(CW-1){1'b0}}, accept};
  assign full    = (cnt_nxt == FULL);
  // cnt_nxt is nonzero exactly when there is something to flush, so an empty flush is dropped here
  assign flush_req = flush_pend || (flush && (cnt_nxt != '0));
  assign emit      = slot_free && (full || flush_req);

  // Align the received bits to their final positions; the unreceived positions take PAD_BIT.
  assign pad_cnt = FULL - cnt_nxt;

  always_comb begin
    if (MSB_FIRST) begin
      shifted   = sr_nxt << pad_cnt;
      keep_mask = {WIDTH{1'b1}} << pad_cnt;
    end else begin
      shifted   = sr_nxt >> pad_cnt;
      keep_mask = {WIDTH{1'b1}} >> pad_cnt;
    end
    assembled = (shifted & keep_mask) | ({WIDTH{PAD_BIT}} & ~keep_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      word_out   <= '0;
      word_len   <= '0;
      word_valid <= 1'b0;
    end else begin
      sr <= sr_nxt;
      if (emit) begin
        word_out   <= assembled;
        word_len   <= cnt_nxt;
        word_valid <= 1'b1;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        // A flush that coincides with word completion rides on the full emit instead of pending.
        flush_pend <= flush_req && !full;
        if (word_ready) word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed bench for serial_word_packer: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_serial_word_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, flush = 1'b0, word_ready = 1'b1;
  logic       m_bit_ready, l_bit_ready, m_word_valid, l_word_valid;
  logic [31:0] m_word_out, l_word_out;
  logic [5:0]  m_word_len, l_word_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_word_packer #(.WIDTH(32), .MSB_FIRST(1'b1), .PAD_BIT(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(m_bit_ready),
    .flush(flush), .word_out(m_word_out), .word_len(m_word_len), .word_valid(m_word_valid),
    .word_ready(word_ready));

  serial_word_packer #(.WIDTH(32), .MSB_FIRST(1'b0), .PAD_BIT(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(l_bit_ready),
    .flush(flush), .word_out(l_word_out), .word_len(l_word_len), .word_valid(l_word_valid),
    .word_ready(word_ready));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic fl);
    bit_in    = b;
    bit_valid = 1'b1;
    flush     = fl;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Overlapping 0-1-0 occurrences, as the downstream counter would see them
  function automatic int count010(input logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 30; i++)
      if (w[i+2 -: 3] == 3'b010) n++;
    return n;
  endfunction

  logic [31:0] vec;
  logic        ready_all, any_valid;

  initial begin
    // Reset state
    #12;
    check("rst_valid", {31'b0, m_word_valid}, 32'd0);
    check("rst_word",  m_word_out, 32'd0);
    check("rst_len",   {26'b0, m_word_len}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_bit_ready", {31'b0, m_bit_ready}, 32'd1);

    // Baseline emit, MSB first
    word_ready = 1'b1;
    vec = 32'h0000_0004;
    ready_all = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ready_all &= m_bit_ready;
      send_bit(vec[31-i], 1'b0);
      if (i == 30) check("base_valid_early", {31'b0, m_word_valid}, 32'd0);
    end
    check("base_valid", {31'b0, m_word_valid}, 32'd1);
    check("base_word",  m_word_out, 32'h0000_0004);
    check("base_len",   {26'b0, m_word_len}, 32'd32);
    check("base_ready_steady", {31'b0, ready_all & m_bit_ready}, 32'd1);
    idle_cycle();
    check("base_valid_drop", {31'b0, m_word_valid}, 32'd0);

    // Backpressure: two words with consumer stalled
    word_ready = 1'b0;
    vec = 32'h5555_5555;
    for (int i = 0; i < 32; i++) send_bit(vec[31-i], 1'b0);
    check("bp_first_valid", {31'b0, m_word_valid}, 32'd1);
    check("bp_first_word",  m_word_out, 32'h5555_5555);
    vec = 32'h4924_9249;
    for (int i = 0; i < 32; i++) send_bit(vec[31-i], 1'b0);
    check("bp_bit_ready_low", {31'b0, m_bit_ready}, 32'd0);
    check("bp_first_hold",    m_word_out, 32'h5555_5555);
    word_ready = 1'b1;
    idle_cycle();
    word_ready = 1'b0;
    check("bp_second_word",  m_word_out, 32'h4924_9249);
    check("bp_valid_kept",   {31'b0, m_word_valid}, 32'd1);
    check("bp_ready_return", {31'b0, m_bit_ready}, 32'd1);
    word_ready = 1'b1;
    idle_cycle();
    check("bp_valid_drop", {31'b0, m_word_valid}, 32'd0);

    // Partial flush after 0,1,0,1,0
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    check("pf_no_word_yet", {31'b0, m_word_valid}, 32'd0);
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    check("pf_valid", {31'b0, m_word_valid}, 32'd1);
    check("pf_word",  m_word_out, 32'h57FF_FFFF);
    check("pf_len",   {26'b0, m_word_len}, 32'd5);
    check("pf_count010", count010(m_word_out), 32'd2);
    idle_cycle();
    check("pf_valid_drop", {31'b0, m_word_valid}, 32'd0);

    // Flush with nothing collected
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    check("fe_no_word", {31'b0, m_word_valid}, 32'd0);
    idle_cycle();
    check("fe_no_word_later", {31'b0, m_word_valid}, 32'd0);

    // Flush coincident with the 32nd bit
    vec = 32'hA5A5_A5A5;
    for (int i = 0; i < 32; i++) send_bit(vec[31-i], i == 31);
    check("fc_valid", {31'b0, m_word_valid}, 32'd1);
    check("fc_word",  m_word_out, 32'hA5A5_A5A5);
    check("fc_len",   {26'b0, m_word_len}, 32'd32);
    idle_cycle();
    check("fc_no_extra", {31'b0, m_word_valid}, 32'd0);
    idle_cycle();
    check("fc_no_extra2", {31'b0, m_word_valid}, 32'd0);

    // Flush while the output slot is busy
    word_ready = 1'b0;
    vec = 32'h0000_FFFF;
    for (int i = 0; i < 32; i++) send_bit(vec[31-i], 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("fb_ready_before", {31'b0, m_bit_ready}, 32'd1);
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    check("fb_ready_low",  {31'b0, m_bit_ready}, 32'd0);
    check("fb_hold_word",  m_word_out, 32'h0000_FFFF);
    idle_cycle();
    check("fb_ready_low2", {31'b0, m_bit_ready}, 32'd0);
    word_ready = 1'b1;
    idle_cycle();
    check("fb_word",      m_word_out, 32'hBFFF_FFFF);
    check("fb_len",       {26'b0, m_word_len}, 32'd3);
    check("fb_valid",     {31'b0, m_word_valid}, 32'd1);
    check("fb_ready_ret", {31'b0, m_bit_ready}, 32'd1);
    idle_cycle();
    check("fb_valid_drop", {31'b0, m_word_valid}, 32'd0);

    // Reset mid-word discards the 17 collected bits
    for (int i = 0; i < 17; i++) send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_valid_in_rst", {31'b0, m_word_valid}, 32'd0);
    check("mr_len_in_rst",   {26'b0, m_word_len}, 32'd0);
    idle_cycle();
    rst_n = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_bit(1'b1, 1'b0);
      if (i < 31) any_valid |= m_word_valid;
    end
    check("mr_no_early_word", {31'b0, any_valid}, 32'd0);
    check("mr_word", m_word_out, 32'hFFFF_FFFF);
    check("mr_len",  {26'b0, m_word_len}, 32'd32);
    idle_cycle();

    // LSB-first instance, from a fresh reset
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    vec = 32'h0000_0004;
    for (int i = 0; i < 32; i++) send_bit(vec[i], 1'b0);
    check("lsb_valid", {31'b0, l_word_valid}, 32'd1);
    check("lsb_word",  l_word_out, 32'h0000_0004);
    check("lsb_len",   {26'b0, l_word_len}, 32'd32);
    idle_cycle();
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    check("lsb_pf_valid", {31'b0, l_word_valid}, 32'd1);
    check("lsb_pf_word",  l_word_out, 32'hFFFF_FFFE);
    check("lsb_pf_len",   {26'b0, l_word_len}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_packer.md
Name: serial_word_packer

Overview:
- Upstream feeder for the combinational 32-bit pattern counter.
- Collects a serial bit stream into WIDTH-bit words and presents each word with a valid/ready handshake. The word_out bus drives the counter's din directly.
- Supports a flush command that emits a partial word. The padding is chosen so it can never create a spurious 0-1-0 occurrence.

Parameters:
WIDTH, 32, word width in bits; legal range 4..32.
MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].
PAD_BIT, 1'b1, fill value for unreceived bit positions on a flushed partial word.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
bit_in  input  1  serial data bit.
bit_valid  input  1  bit_in is valid this cycle.
bit_ready  output  1  packer can accept a bit this cycle.
flush  input  1  single-cycle request to emit the partial word.
word_out  output  WIDTH  assembled word.
word_len  output  $clog2(WIDTH+1)  number of received (non-pad) bits in word_out.
word_valid  output  1  word_out/word_len are valid.
word_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - shift register = 0, bit count cnt = 0, flush_pend = 0.
  - word_out = 0, word_len = 0, word_valid = 0.
  - bit_ready = 1 once rst_n is high.
- Bit accept:
  - A bit is accepted on a rising edge with bit_valid && bit_ready.
  - MSB_FIRST=1: sr <= {sr[W-2:0], bit_in}. MSB_FIRST=0: sr <= {bit_in, sr[W-1:1]}.
  - cnt increments by 1 per accepted bit.
- bit_ready = (cnt != WIDTH) && !flush_pend, decoded from registers only (no combinational path from bit_valid).
- Output slot free = !word_valid || word_ready.
- Full emit:
  - Triggered when cnt reaches WIDTH, including the edge on which the WIDTH-th bit is accepted.
  - If the slot is free, on the same edge: word_out <= assembled word, word_len <= WIDTH, word_valid <= 1, cnt <= 0.
  - Latency: word_valid is high in the cycle after the WIDTH-th bit is accepted.
  - If the slot is not free: cnt holds at WIDTH, bit_ready = 0, and the emit occurs on the first edge where the slot is free.
- Flush:
  - Ignored when cnt == 0 and no bit is accepted that cycle.
  - A bit accepted in the same cycle is included first.
  - If that bit completes the word, a normal full emit occurs and the flush is consumed with no extra word.
  - Otherwise the partial word is emitted when the slot is free. While waiting, flush_pend = 1 and bit_ready = 0.
  - Partial layout:
    - MSB_FIRST=1: received bits occupy [W-1 : W-cnt] in arrival order; the rest is PAD_BIT.
    - MSB_FIRST=0: received bits occupy [cnt-1 : 0]; the rest is PAD_BIT.
  - word_len = cnt. Then cnt <= 0 and flush_pend <= 0.
- Handshake:
  - While word_valid && !word_ready, word_out and word_len hold stable.
  - word_valid falls only after a word_ready handshake with no new emit on that edge.
  - Back-to-back: if handshake and emit coincide, the new word loads and word_valid stays 1.
- Reset mid-operation discards the partial word, any pending flush and the held output word. No remnant bits leak into the next word.
- The bit counter never exceeds WIDTH. There is no silent data loss: backpressure is via bit_ready only.

Test Plan:
- Baseline emit (MSB_FIRST=1, word_ready=1): send 0x00000004 MSB first → word_out=0x00000004 and word_len=32, with word_valid high exactly one cycle after the 32nd bit; bit_ready never drops.
- Backpressure (word_ready=0): stream 0x55555555 then 0x49249249 →
  - first word holds stable;
  - bit_ready=0 after the 64th bit;
  - raising word_ready for one cycle loads 0x49249249 with word_valid kept high, and bit_ready returns to 1 the next cycle.
- Partial flush: bits 0,1,0,1,0 then flush → word_out=0x57FFFFFF, word_len=5. Downstream count equals 2 (no pad-induced matches).
- Flush corner cases:
  - flush with cnt=0 → no word;
  - flush coincident with the 32nd bit → exactly one word, word_len=32;
  - flush while the slot is busy → bit_ready=0 until the partial word emits.
- Reset mid-word: 17 bits, assert rst_n low for 1 cycle, then 32 ones → only 0xFFFFFFFF with word_len=32 appears.
- LSB-first instance (MSB_FIRST=0): send 0x00000004 LSB first → word_out=0x00000004. Flush after bits 0,1 → word_out=0xFFFFFFFE, word_len=2.
